tx_payload_chain_ble_v2: RTL
============================

# tx_payload_chain_ble_v2

Parametrised, backpressure-aware BLE payload transmit chain. It accepts a bit-serial payload and appends an optional CRC-16. It then applies optional whitening and an optional rate-1/2 convolutional encoder with tail flush, and maps coded bit pairs onto QPSK symbols. It sits between the link-layer payload source and the PHY symbol shaper, and replaces the fixed-function payload chain with a framed, start/done-controlled block that has valid/ready on both sides.

## Interface
- RE_IM_SIZE, 12, width of signed out_re/out_im.
- AMP, 12'sd1024, QPSK magnitude. Must fit RE_IM_SIZE signed.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle pulse. Latches all config inputs. Ignored while busy=1.
- n_bits  in  16  payload length in bits, 0..65535.
- uap  in  8  CRC seed, low byte.
- whiten_seed  in  6  whitening seed.
- crc_en, whiten_en, fec_en  in  1 each  stage enables, latched at start.
- in_valid  in  1  payload bit valid.
- in_data  in  1  payload bit, LSB-first.
- in_ready  out  1  chain accepts in_data this cycle.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accepts symbol.
- out_re, out_im  out  RE_IM_SIZE  signed symbol, ±AMP.
- out_last  out  1  qualifies the final symbol of the frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when frame completes.
- sym_count  out  16  symbols handshaken this frame. Cleared at start.
- Reset values: in_ready=0, out_valid=0, out_re=out_im=0, out_last=0, busy=0, done=0, sym_count=0, FSM=IDLE.

## Operation
- FSM: IDLE → PAYLOAD → CRC → TAIL → PAD → FLUSH → IDLE.
  - Empty stages are skipped: n_bits=0, crc_en=0, fec_en=0, or no pad needed.
- One source bit advances per cycle when `adv` = (symbol register empty or out_ready).
- In PAYLOAD: in_ready = adv. A bit is consumed on in_valid & in_ready. After n_bits accepted → CRC.
- CRC-16 (poly x^16+x^12+x^5+1):
  - Init {8'h00, uap}.
  - Bit-serial: fb = in ^ crc[15]; crc <= {crc[14:0],0} ^ (fb ? 16'h1021 : 0).
  - CRC state emits crc[15] first, 16 bits. These bits are not folded into the CRC.
- Whitening applies to payload and CRC bits. 7-bit LFSR x^7+x^4+1, init {1'b1, whiten_seed}.
  - Output = bit ^ l[6].
  - Next: {l[5], l[4], l[3]^l[6], l[2], l[1], l[0], l[6]}.
  - whiten_en=0 passes bits through unchanged and holds the LFSR.
- FEC: K=4 encoder, g0=1111, g1=1011. Emits g0 bit then g1 bit per input.
  - TAIL feeds 3 zero bits (not whitened) to flush the encoder.
  - fec_en=0: one coded bit per source bit, no TAIL.
- Mapper pairs coded bits (b0 first): re = b0 ? -AMP : +AMP, im = b1 ? -AMP : +AMP.
- Coded length C = (n_bits + 16·crc_en + 3·fec_en)·(1+fec_en). If C is odd, PAD appends one 0 bit.
- Symbols per frame = ceil(C/2). out_last is asserted with the last symbol.
- FLUSH waits for the final out handshake, then pulses done and returns to IDLE.
- If C=0, done pulses 2 cycles after start with no symbols.
- sym_count increments on out_valid & out_ready. It holds after done until the next start.

## Timing
- Symbol register: out_valid rises the cycle after the cycle its second coded bit is produced.
- With fec_en=1 and no stall: 1 symbol per cycle after a 2-cycle fill (start → in_ready=1 next cycle).
- With fec_en=0: 1 symbol per 2 source bits.
- Backpressure: out_valid=1 & out_ready=0 holds out_re/out_im/out_last stable, forces in_ready=0, and freezes CRC/LFSR/encoder state.
- in_valid=0 in PAYLOAD stalls the pipeline without bubbles in coded-bit order.
- A start pulse while busy=1 has no effect.
- Reset asserted mid-frame returns everything to reset values immediately. No done pulse.

## Configuration
- TX_PAYLOAD_FEC_EN defined: encoder and TAIL state built; fec_en honoured.
- Undefined: encoder and TAIL are not built, fec_en is ignored (treated as 0), and C = n_bits + 16·crc_en.

## Test plan
- n_bits=8, data 0xFF, all enables 0 → 4 symbols (-AMP,-AMP), out_last on 4th, sym_count=4, done pulse.
- n_bits=0, crc_en=1, uap=0, others 0 → 16 zero CRC bits → 8 symbols (+AMP,+AMP).
- n_bits=4, zero data, whiten_en=1, whiten_seed=0 → bits 1,0,0,1 → symbols (-AMP,+AMP), (+AMP,-AMP).
- n_bits=8, zero data, fec_en=1 (macro defined) → 22 zero coded bits → 11 symbols (+AMP,+AMP), last on 11th.
- n_bits=8, data 0x01, fec_en=1 → first symbol (-AMP,-AMP), then (-AMP,+AMP); 11 symbols total.
- n_bits=9, fec_en=0 → 5 symbols with pad. Hold out_ready=0 for 5 cycles mid-frame → symbol stable, in_ready=0, no bit lost.
- Separately, assert reset on symbol 3 → all outputs 0, busy=0, no done pulse.

Source files
------------

// File: rtl/tx_payload_chain_ble_v2.sv
// BLE payload transmit chain: bit-serial payload -> CRC-16 -> whitening -> rate-1/2 FEC -> QPSK.
// Build with TX_PAYLOAD_FEC_EN defined to include the convolutional encoder and tail flush.
module tx_payload_chain_ble_v2 #(
    parameter int unsigned                    RE_IM_SIZE = 12,
    parameter logic signed [RE_IM_SIZE-1:0]   AMP        = 12'sd1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [15:0]                  n_bits,
    input  logic [7:0]                   uap,
    input  logic [5:0]                   whiten_seed,
    input  logic                         crc_en,
    input  logic                         whiten_en,
    input  logic                         fec_en,
    input  logic                         in_valid,
    input  logic                         in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [RE_IM_SIZE-1:0] out_re,
    output logic signed [RE_IM_SIZE-1:0] out_im,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  sym_count
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SYM_W = 17;
    localparam logic signed [RE_IM_SIZE-1:0] NEG_AMP = -AMP;

    typedef enum logic [2:0] {IDLE, PAYLOAD, CRC, TAIL, PAD, FLUSH} state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [CNT_W-1:0]               nbits_q, nbits_d;
    logic                           crc_en_q, crc_en_d;
    logic                           wh_q, wh_d;
    logic [15:0]                    crc_q, crc_d;
    logic [6:0]                     lfsr_q, lfsr_d;
    logic                           half_q, half_d;
    logic                           b0_q, b0_d;
    logic [SYM_W-1:0]               sym_total_q, sym_total_d;
    logic [SYM_W-1:0]               sym_loaded_q, sym_loaded_d;
    logic                           out_valid_q, out_valid_d;
    logic signed [RE_IM_SIZE-1:0]   re_q, re_d;
    logic signed [RE_IM_SIZE-1:0]   im_q, im_d;
    logic                           last_q, last_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic [CNT_W-1:0]               sym_count_q, sym_count_d;

    logic adv, src_fire, src_bit, src_white, wbit, load, sym_b0, sym_b1;
    logic fec_in, fec_cur;

`ifdef TX_PAYLOAD_FEC_EN
    logic       fec_q, fec_d;
    logic [2:0] enc_q, enc_d;
    assign fec_in  = fec_en;
    assign fec_cur = fec_q;
`else
    logic unused_fec_en;
    assign unused_fec_en = fec_en;
    assign fec_in  = 1'b0;
    assign fec_cur = 1'b0;
`endif

    // First non-empty stage following stage s of the frame.
    function automatic state_e stage_after(input state_e s, input logic [CNT_W-1:0] n,
                                           input logic crc, input logic fec);
        stage_after = FLUSH;
        if (s == IDLE && n != '0)
            stage_after = PAYLOAD;
        else if ((s == IDLE || s == PAYLOAD) && crc)
            stage_after = CRC;
        else if ((s == IDLE || s == PAYLOAD || s == CRC) && fec)
            stage_after = TAIL;
        else if (s != PAD && !fec && n[0])
            stage_after = PAD;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            nbits_q      <= '0;
            crc_en_q     <= 1'b0;
            wh_q         <= 1'b0;
            crc_q        <= '0;
            lfsr_q       <= '0;
            half_q       <= 1'b0;
            b0_q         <= 1'b0;
            sym_total_q  <= '0;
            sym_loaded_q <= '0;
            out_valid_q  <= 1'b0;
            re_q         <= '0;
            im_q         <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sym_count_q  <= '0;
`ifdef TX_PAYLOAD_FEC_EN
            fec_q        <= 1'b0;
            enc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nbits_q      <= nbits_d;
            crc_en_q     <= crc_en_d;
            wh_q         <= wh_d;
            crc_q        <= crc_d;
            lfsr_q       <= lfsr_d;
            half_q       <= half_d;
            b0_q         <= b0_d;
            sym_total_q  <= sym_total_d;
            sym_loaded_q <= sym_loaded_d;
            out_valid_q  <= out_valid_d;
            re_q         <= re_d;
            im_q         <= im_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sym_count_q  <= sym_count_d;
`ifdef TX_PAYLOAD_FEC_EN
            fec_q        <= fec_d;
            enc_q        <= enc_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nbits_d      = nbits_q;
        crc_en_d     = crc_en_q;
        wh_d         = wh_q;
        crc_d        = crc_q;
        lfsr_d       = lfsr_q;
        half_d       = half_q;
        b0_d         = b0_q;
        sym_total_d  = sym_total_q;
        sym_loaded_d = sym_loaded_q;
        out_valid_d  = out_valid_q;
        re_d         = re_q;
        im_d         = im_q;
        last_d       = last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        sym_count_d  = sym_count_q;
`ifdef TX_PAYLOAD_FEC_EN
        fec_d        = fec_q;
        enc_d        = enc_q;
`endif
        in_ready     = 1'b0;
        src_fire     = 1'b0;
        src_bit      = 1'b0;
        src_white    = 1'b0;
        load         = 1'b0;
        sym_b0       = 1'b0;
        sym_b1       = 1'b0;
        adv          = !out_valid_q || out_ready;

        if (out_valid_q && out_ready)
            sym_count_d = sym_count_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = stage_after(IDLE, n_bits, crc_en, fec_in);
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    nbits_d      = n_bits;
                    crc_en_d     = crc_en;
                    wh_d         = whiten_en;
                    crc_d        = {8'h00, uap};
                    lfsr_d       = {1'b1, whiten_seed};
                    half_d       = 1'b0;
                    sym_loaded_d = '0;
                    sym_count_d  = '0;
                    sym_total_d  = fec_in
                        ? 17'(n_bits) + (crc_en ? 17'd16 : 17'd0) + 17'd3
                        : (17'(n_bits) + (crc_en ? 17'd16 : 17'd0) + 17'd1) >> 1;
`ifdef TX_PAYLOAD_FEC_EN
                    fec_d        = fec_en;
                    enc_d        = '0;
`endif
                end
            end
            PAYLOAD: begin
                in_ready = adv;
                if (adv && in_valid) begin
                    src_fire  = 1'b1;
                    src_bit   = in_data;
                    src_white = 1'b1;
                    crc_d     = {crc_q[14:0], 1'b0} ^ ((in_data ^ crc_q[15]) ? 16'h1021 : 16'h0000);
                    if (cnt_q == nbits_q - 16'd1) begin
                        state_d = stage_after(PAYLOAD, nbits_q, crc_en_q, fec_cur);
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
            end
            CRC: begin
                if (adv) begin
                    src_fire  = 1'b1;
                    src_bit   = crc_q[15];
                    src_white = 1'b1;
                    crc_d     = {crc_q[14:0], 1'b0};
                    if (cnt_q == 16'd15) begin
                        state_d = stage_after(CRC, nbits_q, crc_en_q, fec_cur);
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
            end
`ifdef TX_PAYLOAD_FEC_EN
            TAIL: begin
                if (adv) begin
                    src_fire = 1'b1;
                    if (cnt_q == 16'd2) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
            end
`endif
            PAD: begin
                if (adv) begin
                    src_fire = 1'b1;
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                // Last symbol either already drained or handshaking this cycle.
                if (adv) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wbit = src_bit ^ (src_white & wh_q & lfsr_q[6]);
        if (src_fire && src_white && wh_q)
            lfsr_d = {lfsr_q[5], lfsr_q[4], lfsr_q[3] ^ lfsr_q[6], lfsr_q[2:0], lfsr_q[6]};

        // Coded-bit pairing: FEC yields a full pair per source bit, otherwise pair up bits.
        if (src_fire) begin
`ifdef TX_PAYLOAD_FEC_EN
            if (fec_q) begin
                load   = 1'b1;
                sym_b0 = wbit ^ enc_q[0] ^ enc_q[1] ^ enc_q[2];
                sym_b1 = wbit ^ enc_q[1] ^ enc_q[2];
                enc_d  = {enc_q[1:0], wbit};
            end else
`endif
            if (half_q) begin
                load   = 1'b1;
                sym_b0 = b0_q;
                sym_b1 = wbit;
                half_d = 1'b0;
            end else begin
                b0_d   = wbit;
                half_d = 1'b1;
            end
        end

        if (load) begin
            out_valid_d  = 1'b1;
            re_d         = sym_b0 ? NEG_AMP : AMP;
            im_d         = sym_b1 ? NEG_AMP : AMP;
            last_d       = (sym_loaded_q == sym_total_q - 17'd1);
            sym_loaded_d = sym_loaded_q + 17'd1;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
            last_d       = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sym_count = sym_count_q;

endmodule
